// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcode constants and datapath select encodings
// for the multicycle controller and its wait timer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction opcode and status in,
// PC, memory, register-file and ALU controls out.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite;
    logic [1:0] pc_source;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, pc_source, iord, memread, memwrite, irwrite, regdst,
               memtoreg, regwrite, alusrca, alusrcb, aluop, illegal_op,
               mem_timeout, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, pc_source, iord, memread, memwrite, irwrite, regdst,
               memtoreg, regwrite, alusrca, alusrcb, aluop, illegal_op,
               mem_timeout, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on memory; expire is combinational in the
// cycle the count reaches TIMEOUT-1 with ready still low (ready wins).
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expire
);
    logic [CNT_W-1:0] cnt;

    assign expire = count_en && !ready && (cnt == CNT_W'(TIMEOUT - 1));

    // An expiry restarts the count so a re-fetch gets a full wait window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else if (count_en && !ready)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: Moore decode of state, with pcwrite/irwrite
// qualified by mem_ready or zero; memory states wait on mem_ready up to TIMEOUT cycles.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    state_t state;
    logic   waiting;
    logic   expire;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!waiting || bus.mem_ready),
        .count_en (waiting),
        .ready    (bus.mem_ready),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_R:         state <= S_EXEC_R;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EX;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: begin
                    if (bus.opcode == OP_SW)      state <= S_MEM_WR;
                    else if (bus.opcode == OP_LW) state <= S_MEM_RD;
                    else                          state <= S_FETCH;
                end
                S_MEM_RD: begin
                    if (bus.mem_ready)  state <= S_MEM_WB;
                    else if (expire)    state <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (bus.mem_ready || expire) state <= S_FETCH;
                end
                S_EXEC_R:  state <= S_R_WB;
                S_ADDI_EX: state <= S_ADDI_WB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pc_source   = PCSRC_INC;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = SRCB_B;
        bus.aluop       = ALUOP_ADD;
        bus.illegal_op  = 1'b0;
        bus.mem_timeout = expire;
        bus.state_dbg   = state;
        case (state)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.alusrcb = SRCB_ONE;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alusrcb    = SRCB_BROFF;
                bus.illegal_op = !is_legal_op(bus.opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEM_WB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEM_WR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            S_EXEC_R: begin
                bus.alusrca = 1'b1;
                bus.aluop   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca   = 1'b1;
                bus.aluop     = ALUOP_SUB;
                bus.pc_source = PCSRC_ALUOUT;
                bus.pcwrite   = bus.zero;
            end
            S_JUMP: begin
                bus.pcwrite   = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: bus.regwrite = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle bench: table of instruction walks plus timeout and async-reset sequences.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    // {state, pcwrite, pc_source, irwrite, iord, memread, memwrite,
    //  regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, illegal_op, mem_timeout}
    typedef logic [20:0] out_t;
    localparam out_t E_FETCH_W  = 21'b0000_0_00_0_0_1_0_0_0_0_0_01_00_0_0;
    localparam out_t E_FETCH_GO = 21'b0000_1_00_1_0_1_0_0_0_0_0_01_00_0_0;
    localparam out_t E_FETCH_TO = 21'b0000_0_00_0_0_1_0_0_0_0_0_01_00_0_1;
    localparam out_t E_DECODE   = 21'b0001_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam out_t E_DEC_ILL  = 21'b0001_0_00_0_0_0_0_0_0_0_0_11_00_1_0;
    localparam out_t E_MADDR    = 21'b0010_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam out_t E_MRD      = 21'b0011_0_00_0_1_1_0_0_0_0_0_00_00_0_0;
    localparam out_t E_MRD_TO   = 21'b0011_0_00_0_1_1_0_0_0_0_0_00_00_0_1;
    localparam out_t E_MWB      = 21'b0100_0_00_0_0_0_0_0_1_1_0_00_00_0_0;
    localparam out_t E_MWR      = 21'b0101_0_00_0_1_0_1_0_0_0_0_00_00_0_0;
    localparam out_t E_EXR      = 21'b0110_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam out_t E_RWB      = 21'b0111_0_00_0_0_0_0_1_0_1_0_00_00_0_0;
    localparam out_t E_BR0      = 21'b1000_0_01_0_0_0_0_0_0_0_1_00_01_0_0;
    localparam out_t E_BR1      = 21'b1000_1_01_0_0_0_0_0_0_0_1_00_01_0_0;
    localparam out_t E_JMP      = 21'b1001_1_10_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam out_t E_AEX      = 21'b1010_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam out_t E_AWB      = 21'b1011_0_00_0_0_0_0_0_0_1_0_00_00_0_0;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        string      name;
        logic [5:0] opc;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    vec_t  tbl[$];
    out_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic out_t observed();
        return {bus.state_dbg, bus.pcwrite, bus.pc_source, bus.irwrite, bus.iord,
                bus.memread, bus.memwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.aluop, bus.illegal_op, bus.mem_timeout};
    endfunction

    task automatic add(input string nm, input logic [5:0] opc, input logic z,
                       input logic rdy, input out_t e);
        vec_t v;
        v.name = nm; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic expect_now(input string nm, input out_t e);
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic compare();
        out_t  got;
        out_t  e;
        string nm;
        got = observed();
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%b", got);
        end else begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%b expected=%b", nm, got, e);
            end
        end
    endtask

    // Drive one cycle's inputs mid-cycle, compare at the falling edge, then cross the rising edge.
    task automatic step(input string nm, input logic [5:0] opc, input logic z,
                        input logic rdy, input out_t e);
        bus.opcode    = opc;
        bus.zero      = z;
        bus.mem_ready = rdy;
        expect_now(nm, e);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = R; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        add("r_fetch", R, 0, 1, E_FETCH_GO);  add("r_decode", R, 0, 1, E_DECODE);
        add("r_exec", R, 0, 1, E_EXR);        add("r_wb", R, 0, 1, E_RWB);
        add("lw_fetch", LW, 0, 1, E_FETCH_GO); add("lw_decode", LW, 0, 1, E_DECODE);
        add("lw_addr", LW, 0, 1, E_MADDR);
        add("lw_wait1", LW, 0, 0, E_MRD); add("lw_wait2", LW, 0, 0, E_MRD);
        add("lw_wait3", LW, 0, 0, E_MRD); add("lw_rd", LW, 0, 1, E_MRD);
        add("lw_wb", LW, 0, 1, E_MWB);
        add("sw_fetch", SW, 0, 1, E_FETCH_GO); add("sw_decode", SW, 0, 1, E_DECODE);
        add("sw_addr", SW, 0, 1, E_MADDR);     add("sw_wr", SW, 0, 1, E_MWR);
        add("beq1_fetch", BEQ, 1, 1, E_FETCH_GO); add("beq1_decode", BEQ, 1, 1, E_DECODE);
        add("beq1_taken", BEQ, 1, 1, E_BR1);
        add("beq0_fetch", BEQ, 0, 1, E_FETCH_GO); add("beq0_decode", BEQ, 0, 1, E_DECODE);
        add("beq0_not_taken", BEQ, 0, 1, E_BR0);
        add("j_fetch", J, 0, 1, E_FETCH_GO);   add("j_decode", J, 0, 1, E_DECODE);
        add("j_jump", J, 0, 1, E_JMP);
        add("ill_fetch", BAD, 0, 1, E_FETCH_GO); add("ill_decode", BAD, 0, 1, E_DEC_ILL);
        add("ill_back", R, 0, 1, E_FETCH_GO);    add("ill_next_decode", R, 0, 1, E_DECODE);
        add("ill_next_exec", R, 0, 1, E_EXR);    add("ill_next_wb", R, 0, 1, E_RWB);
        add("addi_fetch", ADDI, 0, 1, E_FETCH_GO);
        add("addi_decode_rdy0", ADDI, 0, 0, E_DECODE);
        add("addi_ex_rdy0", ADDI, 0, 0, E_AEX);  add("addi_wb", ADDI, 0, 1, E_AWB);

        #2;
        expect_now("reset_state", E_FETCH_W);
        compare();
        #5;
        expect_now("reset_held_over_edge", E_FETCH_W);
        compare();
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i].name, tbl[i].opc, tbl[i].z, tbl[i].rdy, tbl[i].exp);

        // Fetch timeout: 15 idle cycles, abort pulse on the 16th.
        for (int k = 1; k <= 15; k++) step($sformatf("fetch_wait%0d", k), LW, 0, 0, E_FETCH_W);
        step("fetch_timeout", LW, 0, 0, E_FETCH_TO);
        // Fresh window: ready on the 16th cycle beats the timeout.
        for (int k = 1; k <= 15; k++) step($sformatf("refetch_wait%0d", k), LW, 0, 0, E_FETCH_W);
        step("fetch_ready_at_boundary", LW, 0, 1, E_FETCH_GO);
        step("lw2_decode", LW, 0, 0, E_DECODE);
        step("lw2_addr", LW, 0, 0, E_MADDR);
        for (int k = 1; k <= 15; k++) step($sformatf("mrd_wait%0d", k), LW, 0, 0, E_MRD);
        step("mrd_timeout", LW, 0, 0, E_MRD_TO);
        step("after_mrd_timeout", LW, 0, 0, E_FETCH_W);

        // Async reset while a store is in progress.
        step("sw2_fetch", SW, 0, 1, E_FETCH_GO);
        step("sw2_decode", SW, 0, 1, E_DECODE);
        step("sw2_addr", SW, 0, 0, E_MADDR);
        step("sw2_wr_wait", SW, 0, 0, E_MWR);
        bus.mem_ready = 1'b0;
        expect_now("sw2_wr_before_reset", E_MWR);
        compare();
        #2;
        rst = 1'b1;
        #1;
        expect_now("async_reset_mid_write", E_FETCH_W);
        compare();
        rst = 1'b0;
        step("post_reset_fetch", R, 0, 1, E_FETCH_GO);
        step("post_reset_decode", R, 0, 1, E_DECODE);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM that drives the program counter's `pcwrite`/`pc_source` interface and the datapath enables for a word-addressed 32-bit MIPS-subset core.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WB steps.
- Resolves branch conditions internally using `zero`, so the PC sees a single `pcwrite` strobe.
- Handshakes with instruction/data memory via `mem_ready`, with a bounded wait timeout.

Parameters:
- TIMEOUT, 16, maximum cycles spent waiting for `mem_ready` in a memory state before abort.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  instruction register bits [31:26]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  PC load strobe
- pc_source  out  2  PC next-value select: 00 = PC+1, 01 = registered ALU out, 10 = jump address, 11 = live ALU result
- iord  out  1  memory address select: 0 = PC, 1 = ALU out
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 1 = rd, 0 = rt
- memtoreg  out  1  write-back data select: 1 = MDR, 0 = ALU out
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B select: 00 = B, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext imm (branch offset)
- aluop  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse on a memory wait abort
- state_dbg  out  4  current state encoding

Behaviour:
- State register plus wait counter. Outputs are a Moore decode of state, except `pcwrite` and `irwrite`, which are qualified by `mem_ready` or `zero` as stated below.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Reset: state=FETCH and counter=0. All outputs take their FETCH decode: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pc_source`=00. `pcwrite`, `irwrite`, `illegal_op`, `mem_timeout`, `regwrite` and `memwrite` are 0. `state_dbg`=0.
- FETCH:
  - Hold `memread`.
  - When `mem_ready`=1, assert `irwrite`=1 and `pcwrite`=1 with `pc_source`=00, then go to DECODE.
  - Otherwise stay and increment the counter.
- DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00 (branch target into ALU out). Dispatch on opcode:
  - LW or SW → MEM_ADDR
  - R → EXEC_R
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EX
  - any other opcode → pulse `illegal_op`, go to FETCH
- MEM_ADDR: `alusrca`=1, `alusrcb`=10, `aluop`=00. LW → MEM_RD; SW → MEM_WR.
- MEM_RD: `memread`=1, `iord`=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Go to FETCH.
- MEM_WR: `memwrite`=1, `iord`=1. Wait for `mem_ready`, then go to FETCH.
- EXEC_R: `alusrca`=1, `alusrcb`=00, `aluop`=10. Go to R_WB.
- R_WB: `regwrite`=1, `regdst`=1, `memtoreg`=0. Go to FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pc_source`=01, `pcwrite`=`zero`. Go to FETCH.
- JUMP: `pcwrite`=1, `pc_source`=10. Go to FETCH.
- ADDI_EX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Go to ADDI_WB.
- ADDI_WB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Go to FETCH.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with `mem_ready`=0.
  - When counter = TIMEOUT-1 and `mem_ready`=0: pulse `mem_timeout`, go to FETCH (re-fetch from the unchanged PC). No `pcwrite`, `regwrite` or `irwrite` fires on an aborted access.
- `mem_ready` arriving on the same cycle as the timeout boundary: `mem_ready` wins; no timeout.
- `mem_ready` outside FETCH, MEM_RD or MEM_WR is ignored.
- Unused/undefined state encodings (12–15) recover to FETCH on the next clock with all write enables 0.
- Reset mid-instruction: immediate return to FETCH. No partial write strobe survives past reset assertion.
- At most one of `memread`/`memwrite` is high in any cycle. `regwrite` and `memwrite` are never both high.

Decomposition:
- Shared package `ctrl_pkg`:
  - state enum
  - opcode constants
  - `pc_source`, `alusrcb` and `aluop` encodings
- Natural sub-module: `mem_wait_timer`, holding the wait counter and timeout compare, with inputs clear, count_en, ready and output expire.

Test Plan:
- R-type, `mem_ready` tied 1: opcode=000000 → states 0,1,6,7,0. `pcwrite`=1 only in cycle 1 with `pc_source`=00. `regwrite`=1 and `regdst`=1 in the R_WB cycle.
- LW with 3-cycle data wait: opcode=100011, `mem_ready` low for 3 cycles in MEM_RD → 3 extra MEM_RD cycles, then MEM_WB with `memtoreg`=1 and `regwrite`=1. Total 8 cycles.
- BEQ: zero=1 → BRANCH cycle with `pcwrite`=1, `pc_source`=01. Repeat with zero=0 → `pcwrite`=0 and `pc_source`=01.
- J then illegal opcode 111111: J gives `pcwrite`=1, `pc_source`=10 in JUMP. 111111 gives a one-cycle `illegal_op`, state back to 0, no `regwrite` or `memwrite`.
- Timeout, TIMEOUT=16: `mem_ready`=0 throughout FETCH → `mem_timeout` pulses in cycle 16, state stays FETCH, `pcwrite` never asserted. A second run with `mem_ready`=1 at cycle 16 → no timeout, DECODE entered.
- Async reset asserted mid-MEM_WR (`memwrite`=1) → `memwrite` drops with no clock edge, `state_dbg`=0. After release, FETCH resumes with `memread`=1.
